// File: rtl/udma_apb_master_pkg.sv
// Shared types and constants for the uDMA APB initiator.
package udma_apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Read data returned when a transfer is aborted by the ACCESS timeout.
  localparam logic [31:0] TIMEOUT_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/udma_apb_master.sv
// uDMA APB3 initiator: one outstanding single-beat request, full SETUP/ACCESS
// sequence, registered response with error flag.
// Optional feature: define UDMA_APB_MASTER_TIMEOUT_EN to abort ACCESS phases
// that see no PREADY for TIMEOUT_CYCLES consecutive cycles.
module udma_apb_master
  import udma_apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]               req_wdata_i,
  input  logic                      req_rwn_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e state_q, state_n;
  logic   capture;
  logic   complete;
  logic   timeout_hit;
  logic   timeout_expire;

  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               wdata_q;
  logic                      pwrite_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      req_ready_q;
  logic                      rsp_valid_q;
  logic [31:0]               rsp_rdata_q;
  logic                      rsp_err_q;

`ifdef UDMA_APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q;

  // Count consecutive not-ready ACCESS cycles; cleared while in SETUP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      to_cnt_q <= '0;
    end else if (state_q == ACCESS && !PREADY) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end

  // True during the TIMEOUT_CYCLES-th ACCESS cycle.
  assign timeout_expire = (state_q == ACCESS) &&
                          (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_n     = state_q;
    capture     = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          capture = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          complete = 1'b1;
          state_n  = RESP;
        end else if (timeout_expire) begin
          timeout_hit = 1'b1;
          state_n     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request capture; these registers drive the APB address/data/direction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      pwrite_q <= 1'b1;
    end else if (capture) begin
      addr_q   <= req_addr_i;
      wdata_q  <= req_wdata_i;
      pwrite_q <= ~req_rwn_i;
    end
  end

  // Registered handshake and APB phase strobes, decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      psel_q      <= (state_n == SETUP) || (state_n == ACCESS);
      penable_q   <= (state_n == ACCESS);
      req_ready_q <= (state_n == IDLE);
      rsp_valid_q <= (state_n == RESP);
    end
  end

  // Response capture at the end of ACCESS; held through RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (complete) begin
      rsp_rdata_q <= (PSLVERR || pwrite_q) ? 32'h0 : PRDATA;
      rsp_err_q   <= PSLVERR;
    end else if (timeout_hit) begin
`ifdef UDMA_APB_MASTER_TIMEOUT_EN
      rsp_rdata_q <= TIMEOUT_ERR_DATA;
`else
      rsp_rdata_q <= 32'h0;
`endif
      rsp_err_q   <= 1'b1;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign PADDR       = addr_q;
  assign PWDATA      = wdata_q;
  assign PWRITE      = pwrite_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;

endmodule
